// File: rtl/data_mem_access_unit_pkg.sv
// Shared types and encodings for the data-memory access unit: FSM states,
// load funct3 codes and access-size codes.
package data_mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size as carried in funct3[1:0]; 2'b10 and 2'b11 both mean word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Data-memory handshake bus: the unit is master, the memory is slave.
interface data_mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/data_mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension of the returned memory word.
module data_mem_access_unit_load_extend
    import data_mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        // Halfword lane ignores addr[0]: a misaligned half is truncated down.
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data = {{16{half_v[15]}}, half_v};
            F3_LBU:  data = {24'd0, byte_v};
            F3_LHU:  data = {16'd0, half_v};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store responder: FSM, request latches, timeout and store lanes.
// Optional MISALIGN_TRAP_EN adds a misaligned output and skips misaligned accesses.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy_wait,
    output logic        mem_timeout,
`ifdef MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    data_mem_access_unit_if.master mem
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    state_t             state, state_nx;
    logic               req, is_store, misal_req;
    logic [1:0]         size_sel;
    logic               start, capture, abort, expire, misal_hit;
    logic [CNT_W-1:0]   cnt;
    logic               we_p0, ld_p0;
    logic [31:2]        addr_p0;
    logic [3:0]         byteen_p0;
    logic [31:0]        wdata_p0;
    logic [2:0]         f3_p0;
    logic [1:0]         lo_p0;
    logic [31:0]        ext_data;

    assign req      = mem_read[3] | mem_write[2];
    assign is_store = mem_write[2];
    assign size_sel = is_store ? mem_write[1:0] : mem_read[1:0];
    assign expire   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
    assign misal_req = (size_sel == SZ_H) ? address[0]
                                          : (size_sel[1] & (address[1:0] != 2'b00));
`else
    assign misal_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (req) state_nx = misal_req ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (mem.mem_ack || expire) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // rst gates busy_wait so a reset mid-access releases the stall immediately.
    always_comb begin
        busy_wait   = req & (state != ST_DONE) & ~rst;
        mem.mem_req = (state == ST_ACCESS);
        start       = (state == ST_IDLE) & req;
        misal_hit   = start & misal_req;
        capture     = (state == ST_ACCESS) & mem.mem_ack;
        abort       = (state == ST_ACCESS) & ~mem.mem_ack & expire;
    end

    // ---- request capture (control) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p0       <= 1'b0;
            ld_p0       <= 1'b0;
            cnt         <= '0;
            mem_timeout <= 1'b0;
            read_data   <= '0;
        end else begin
            mem_timeout <= abort;
            if (start) begin
                we_p0 <= is_store;
                ld_p0 <= ~is_store;
                cnt   <= '0;
            end else if (state == ST_ACCESS) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (misal_hit || (abort && ld_p0))
                read_data <= '0;
            else if (capture && ld_p0)
                read_data <= ext_data;
        end
    end

    // ---- request capture (data) ----
    always_ff @(posedge clk) begin
        if (start) begin
            addr_p0   <= address[31:2];
            byteen_p0 <= lane_enables(size_sel, address[1:0]);
            wdata_p0  <= lane_data(size_sel, write_data);
            f3_p0     <= mem_read[2:0];
            lo_p0     <= address[1:0];
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misaligned <= 1'b0;
        else     misaligned <= misal_hit;
    end
`endif

    assign mem.mem_we     = we_p0;
    assign mem.mem_addr   = {addr_p0, 2'b00};
    assign mem.mem_byteen = byteen_p0;
    assign mem.mem_wdata  = wdata_p0;

    data_mem_access_unit_load_extend u_load_extend (
        .rdata   (mem.mem_rdata),
        .addr_lo (lo_p0),
        .funct3  (f3_p0),
        .data    (ext_data)
    );
endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: a default-timeout instance and a
// TIMEOUT_CYCLES=4 instance share the stimulus, selected by sel.
module tb_data_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address, write_data, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    data_mem_access_unit_if mif();
    data_mem_access_unit_if tif();

    logic [3:0]  mr_m, mr_t;
    logic [2:0]  mw_m, mw_t;
    logic [31:0] rd_m, rd_t;
    logic        busy_m, busy_t, to_m, to_t;
`ifdef MISALIGN_TRAP_EN
    logic        mis_m, mis_t, o_mis;
`endif

    assign mr_m = sel ? 4'd0 : mem_read;
    assign mw_m = sel ? 3'd0 : mem_write;
    assign mr_t = sel ? mem_read : 4'd0;
    assign mw_t = sel ? mem_write : 3'd0;
    assign mif.mem_rdata = mem_rdata;
    assign tif.mem_rdata = mem_rdata;
    assign mif.mem_ack   = mem_ack & ~sel;
    assign tif.mem_ack   = mem_ack & sel;

    data_mem_access_unit dut (
        .clk(clk), .rst(rst), .mem_read(mr_m), .mem_write(mw_m),
        .address(address), .write_data(write_data), .read_data(rd_m),
        .busy_wait(busy_m), .mem_timeout(to_m),
`ifdef MISALIGN_TRAP_EN
        .misaligned(mis_m),
`endif
        .mem(mif.master)
    );

    data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .mem_read(mr_t), .mem_write(mw_t),
        .address(address), .write_data(write_data), .read_data(rd_t),
        .busy_wait(busy_t), .mem_timeout(to_t),
`ifdef MISALIGN_TRAP_EN
        .misaligned(mis_t),
`endif
        .mem(tif.master)
    );

    logic        o_busy, o_to, o_req, o_we;
    logic [31:0] o_rd, o_addr, o_wd;
    logic [3:0]  o_be;
    assign o_busy = sel ? busy_t : busy_m;
    assign o_to   = sel ? to_t : to_m;
    assign o_rd   = sel ? rd_t : rd_m;
    assign o_req  = sel ? tif.mem_req : mif.mem_req;
    assign o_we   = sel ? tif.mem_we : mif.mem_we;
    assign o_addr = sel ? tif.mem_addr : mif.mem_addr;
    assign o_be   = sel ? tif.mem_byteen : mif.mem_byteen;
    assign o_wd   = sel ? tif.mem_wdata : mif.mem_wdata;
`ifdef MISALIGN_TRAP_EN
    assign o_mis  = sel ? mis_t : mis_m;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          busy;
        int          reqs;
        logic        to;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] rd, input int busy,
                                input int reqs, input logic to, input logic mis);
        exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wd = wd; e.rd = rd;
        e.busy = busy; e.reqs = reqs; e.to = to; e.mis = mis;
        return e;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        for (int k = 0; k < 4; k++)
            be[k] = (sz == 2'b00) ? (k == int'(lo)) : (sz == 2'b01) ? ((k / 2) == int'(lo[1])) : 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] o;
        for (int k = 0; k < 4; k++)
            o[8*k +: 8] = wd[8*((sz == 2'b00) ? 0 : (sz == 2'b01) ? (k % 2) : k) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b, h;
        b = w >> (8 * lo);
        h = w >> (16 * lo[1]);
        case (f3)
            3'b000:  return 32'($signed(b[7:0]));
            3'b001:  return 32'($signed(h[15:0]));
            3'b100:  return {24'd0, b[7:0]};
            3'b101:  return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    // Drives one request, plays the memory with an ack on the ack_dly-th
    // mem_req cycle (0 = never), and scores the result in the DONE cycle.
    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int ack_dly,
                          input exp_t e);
        exp_t x;
        int   busy_n = 0;
        int   req_n  = 0;
        logic done   = 1'b0;
        exp_q.push_back(e);
        mem_read = rd; mem_write = wr; address = a; write_data = wd;
        mem_rdata = rdat; mem_ack = 1'b0;
        #1;
        for (int c = 0; c < 64; c++) begin
            if (!o_busy) begin
                done = 1'b1;
                break;
            end
            busy_n++;
            mem_ack = 1'b0;
            if (o_req) begin
                req_n++;
                if (req_n == ack_dly) begin
                    check("bus_we", o_we, exp_q[0].we);
                    check("bus_addr", o_addr, exp_q[0].addr);
                    if (exp_q[0].we) begin
                        check("bus_byteen", o_be, exp_q[0].be);
                        check("bus_wdata", o_wd, exp_q[0].wd);
                    end
                    mem_ack = 1'b1;
                end
            end
            @(negedge clk); #1;
        end
        mem_ack = 1'b0;
        x = exp_q.pop_front();
        check("done_reached", done, 1'b1);
        check("read_data", o_rd, x.rd);
        check("busy_cycles", busy_n, x.busy);
        check("req_cycles", req_n, x.reqs);
        check("timeout_flag", o_to, x.to);
`ifdef MISALIGN_TRAP_EN
        check("misaligned", o_mis, x.mis);
`endif
        mem_read = 4'd0; mem_write = 3'd0;
        @(negedge clk); #1;
        check("idle_req", o_req, 1'b0);
        check("idle_timeout", o_to, 1'b0);
    endtask

    initial begin
        logic [2:0] f3tab [5];
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b1; sel = 1'b0; mem_read = 4'd0; mem_write = 3'd0;
        address = 32'd0; write_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_read_data", rd_m, 32'd0);
        check("rst_mem_req", mif.mem_req, 1'b0);
        check("rst_mem_we", mif.mem_we, 1'b0);
        check("rst_timeout", to_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misaligned", mis_m, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk); #1;
        last_rd = 32'd0;

        access(4'b0000, 3'b110, 32'h104, 32'hDEADBEEF, 32'h0, 1,
               mk(1'b1, 32'h104, 4'b1111, 32'hDEADBEEF, last_rd, 2, 1, 1'b0, 1'b0));
        access(4'b1000, 3'b000, 32'h203, 32'h0, 32'h80FFFF00, 1,
               mk(1'b0, 32'h200, 4'b0, 32'h0, 32'hFFFFFF80, 2, 1, 1'b0, 1'b0));
        access(4'b1100, 3'b000, 32'h203, 32'h0, 32'h80FFFF00, 1,
               mk(1'b0, 32'h200, 4'b0, 32'h0, 32'h00000080, 2, 1, 1'b0, 1'b0));
        last_rd = 32'h00000080;
        access(4'b0000, 3'b101, 32'h012, 32'h1234ABCD, 32'h0, 1,
               mk(1'b1, 32'h010, 4'b1100, 32'hABCDABCD, last_rd, 2, 1, 1'b0, 1'b0));
        access(4'b1010, 3'b000, 32'h3F0, 32'h0, 32'h13579BDF, 5,
               mk(1'b0, 32'h3F0, 4'b0, 32'h0, 32'h13579BDF, 6, 5, 1'b0, 1'b0));
        last_rd = 32'h13579BDF;
        // Load and store together: the store runs and read_data keeps its value.
        access(4'b1010, 3'b110, 32'h040, 32'h11112222, 32'h99999999, 1,
               mk(1'b1, 32'h040, 4'b1111, 32'h11112222, last_rd, 2, 1, 1'b0, 1'b0));

        for (int i = 0; i < 8; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [1:0]  sz;
            logic [31:0] a, wd, rw;
            int          dly;
            st  = 1'($urandom_range(0, 1));
            f3  = f3tab[$urandom_range(0, 4)];
            sz  = f3[1:0];
            a   = $urandom & 32'h0000_0FFF;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            wd  = $urandom;
            rw  = $urandom;
            dly = $urandom_range(1, 3);
            if (st) begin
                access(4'b0000, {1'b1, sz}, a, wd, rw, dly,
                       mk(1'b1, {a[31:2], 2'b00}, model_be(sz, a[1:0]), model_wd(sz, wd),
                          last_rd, 1 + dly, dly, 1'b0, 1'b0));
            end else begin
                access({1'b1, f3}, 3'b000, a, wd, rw, dly,
                       mk(1'b0, {a[31:2], 2'b00}, 4'b0, 32'h0, model_load(f3, a[1:0], rw),
                          1 + dly, dly, 1'b0, 1'b0));
                last_rd = model_load(f3, a[1:0], rw);
            end
        end

        // A stray ack while idle must not disturb anything.
        mem_rdata = 32'hFFFFFFFF; mem_ack = 1'b1;
        @(negedge clk); #1;
        mem_ack = 1'b0;
        check("stray_ack_rd", rd_m, last_rd);
        check("stray_ack_req", mif.mem_req, 1'b0);

`ifdef MISALIGN_TRAP_EN
        access(4'b1010, 3'b000, 32'h2, 32'h0, 32'h5A5A5A5A, 1,
               mk(1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1));
        last_rd = 32'h0;
`else
        access(4'b1001, 3'b000, 32'h203, 32'h0, 32'h80017FFF, 1,
               mk(1'b0, 32'h200, 4'b0, 32'h0, 32'hFFFF8001, 2, 1, 1'b0, 1'b0));
        last_rd = 32'hFFFF8001;
        access(4'b1010, 3'b000, 32'h32, 32'h0, 32'h0BADCAFE, 1,
               mk(1'b0, 32'h30, 4'b0, 32'h0, 32'h0BADCAFE, 2, 1, 1'b0, 1'b0));
        last_rd = 32'h0BADCAFE;
`endif

        // Reset in the middle of an access.
        mem_read = 4'b1010; address = 32'h300; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_req", mif.mem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", mif.mem_req, 1'b0);
        check("mid_rst_busy", busy_m, 1'b0);
        check("mid_rst_rd", rd_m, 32'h0);
        mem_read = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        access(4'b1010, 3'b000, 32'h500, 32'h0, 32'h76543210, 2,
               mk(1'b0, 32'h500, 4'b0, 32'h0, 32'h76543210, 3, 2, 1'b0, 1'b0));

        // Timeout instance: a good load first, then one that is never acked.
        sel = 1'b1;
        #1;
        access(4'b1010, 3'b000, 32'h600, 32'h0, 32'h55AA1234, 2,
               mk(1'b0, 32'h600, 4'b0, 32'h0, 32'h55AA1234, 3, 2, 1'b0, 1'b0));
        access(4'b1010, 3'b000, 32'h604, 32'h0, 32'hFFFFFFFF, 0,
               mk(1'b0, 32'h604, 4'b0, 32'h0, 32'h0, 5, 4, 1'b1, 1'b0));
        access(4'b0000, 3'b110, 32'h608, 32'hCAFEBABE, 32'h0, 3,
               mk(1'b1, 32'h608, 4'b1111, 32'hCAFEBABE, 32'h0, 4, 3, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
